dmem_responder: RTL and testbench

Multi-cycle responder for the processor's data-memory port. It accepts a read or write request from the core (`MemoryRead`/`MemoryWrite`, `Address`, `WriteData`), waits a fixed number of cycles, then completes the access against internal 64-bit word storage. Completion is signalled with a one-cycle `Ready` pulse, with `ReadData` registered. It is the memory end of the core's load/store interface and replaces the zero-latency data memory once the pipelined/stalling core lands.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_responder_if.sv | 15 +
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int WORD_BYTES       = 8;
  localparam int WORD_OFFSET_BITS = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory load/store bus.
interface dmem_responder_if;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [63:0] Address;
  logic [63:0] WriteData;
  logic [63:0] ReadData;
  logic        Ready;
  logic        Error;

  modport master (output MemoryRead, MemoryWrite, Address, WriteData,
                  input  ReadData, Ready, Error);
  modport slave  (input  MemoryRead, MemoryWrite, Address, WriteData,
                  output ReadData, Ready, Error);
endinterface

// File: rtl/dmem_array.sv
// 64-bit word storage: synchronous write, registered read (write-first).
module dmem_array #(
  parameter int DEPTH_WORDS = 128,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic             we,
  input  logic [63:0]      wdata,
  input  logic             re,
  output logic [63:0]      rdata
);
  logic [63:0] mem [DEPTH_WORDS];

  // Storage itself is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= we ? wdata : mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle responder for the core data-memory port: accept, wait, complete.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            Reset_L,
  dmem_responder_if.slave bus
);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int IDX_HI = WORD_OFFSET_BITS + IDX_W;

  state_t            state, nxt;
  logic [3:0]        cnt;
  op_t               op_q, op_in, op_cur;
  logic [IDX_W-1:0]  idx_q, idx_cur;
  logic [63:0]       wdata_q, wdata_cur, rdata;
  logic              err_q, err_in, err_cur;
  logic              req, idle, commit, we, re;

  always_comb begin
    req    = bus.MemoryRead | bus.MemoryWrite;
    op_in  = bus.MemoryWrite ? OP_WRITE : OP_READ;
    err_in = (bus.Address[WORD_OFFSET_BITS-1:0] != '0) ||
             (bus.Address[63:IDX_HI] != '0) ||
             (bus.MemoryRead && bus.MemoryWrite);
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req) nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // With zero wait states the access commits on the accepting edge,
  // so the live request must feed the array instead of the capture regs.
  always_comb begin
    idle      = (state == IDLE);
    op_cur    = idle ? op_in : op_q;
    idx_cur   = idle ? bus.Address[IDX_HI-1:WORD_OFFSET_BITS] : idx_q;
    wdata_cur = idle ? bus.WriteData : wdata_q;
    err_cur   = idle ? err_in : err_q;
    commit    = (nxt == RESP) && (state != RESP) && !err_cur;
    we        = commit && (op_cur == OP_WRITE);
    re        = commit && (op_cur == OP_READ);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_NONE;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      bus.Ready <= 1'b0;
      bus.Error <= 1'b0;
    end else begin
      state     <= nxt;
      bus.Ready <= (nxt == RESP);
      bus.Error <= (nxt == RESP) && err_cur;
      if (idle && req) begin
        op_q    <= op_in;
        idx_q   <= bus.Address[IDX_HI-1:WORD_OFFSET_BITS];
        wdata_q <= bus.WriteData;
        err_q   <= err_in;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (CLK),
    .rst_n (Reset_L),
    .idx   (idx_cur),
    .we    (we),
    .wdata (wdata_cur),
    .re    (re),
    .rdata (rdata)
  );

  assign bus.ReadData = rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with 2 wait states, one with 0.
module tb_dmem_responder;
  logic CLK = 1'b0;
  logic Reset_L = 1'b0;
  int   nchk = 0;
  int   nerr = 0;
  bit   tgt = 1'b0;

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(2)) u_dut2 (
    .CLK(CLK), .Reset_L(Reset_L), .bus(bus2));
  dmem_responder #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut0 (
    .CLK(CLK), .Reset_L(Reset_L), .bus(bus0));

  always #5 CLK = ~CLK;

  logic        m_rdy, m_err;
  logic [63:0] m_rd;
  always_comb begin
    m_rdy = tgt ? bus0.Ready    : bus2.Ready;
    m_err = tgt ? bus0.Error    : bus2.Error;
    m_rd  = tgt ? bus0.ReadData : bus2.ReadData;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d);
    if (tgt) begin
      bus0.MemoryRead = rd; bus0.MemoryWrite = wr; bus0.Address = a; bus0.WriteData = d;
    end else begin
      bus2.MemoryRead = rd; bus2.MemoryWrite = wr; bus2.Address = a; bus2.WriteData = d;
    end
  endtask

  // Called at a negedge with the target FSM idle; returns edges to Ready.
  task automatic xact(input logic rd, input logic wr, input logic [63:0] a,
                      input logic [63:0] d, output int n, output logic er);
    drive(rd, wr, a, d);
    n = 0;
    do begin
      @(posedge CLK); n++; @(negedge CLK);
    end while (!m_rdy && n < 20);
    er = m_err;
    drive(1'b0, 1'b0, '0, '0);
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic op_chk(input string tag, input logic rd, input logic wr,
                        input logic [63:0] a, input logic [63:0] d,
                        input int exp_lat, input logic exp_err, input logic [63:0] exp_rd);
    int   n;
    logic er;
    logic [63:0] rd_seen;
    drive(rd, wr, a, d);
    n = 0;
    do begin
      @(posedge CLK); n++; @(negedge CLK);
    end while (!m_rdy && n < 20);
    er = m_err;
    rd_seen = m_rd;
    drive(1'b0, 1'b0, '0, '0);
    @(posedge CLK); @(negedge CLK);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_err"}, {63'd0, er}, {63'd0, exp_err});
    check({tag, "_rdata"}, rd_seen, exp_rd);
  endtask

  initial begin
    int r1, r2, n;
    drive(1'b0, 1'b0, '0, '0);
    tgt = 1'b1; drive(1'b0, 1'b0, '0, '0); tgt = 1'b0;
    repeat (3) @(negedge CLK);
    Reset_L = 1'b1;

    // idle after reset: both responders quiet
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle_rdy2", {63'd0, bus2.Ready}, 64'd0);
      check("idle_err2", {63'd0, bus2.Error}, 64'd0);
      check("idle_rd2",  bus2.ReadData, 64'd0);
      check("idle_rdy0", {63'd0, bus0.Ready}, 64'd0);
    end

    // known background for later "unchanged" checks
    op_chk("bg0",  1'b0, 1'b1, 64'h0,  64'h1111, 3, 1'b0, 64'd0);
    op_chk("bg8",  1'b0, 1'b1, 64'h8,  64'h8888, 3, 1'b0, 64'd0);
    op_chk("bg10", 1'b0, 1'b1, 64'h10, 64'h5555, 3, 1'b0, 64'd0);

    op_chk("wr28", 1'b0, 1'b1, 64'h28, 64'hDEADBEEF_CAFEF00D, 3, 1'b0, 64'd0);
    op_chk("rd28", 1'b1, 1'b0, 64'h28, 64'h0, 3, 1'b0, 64'hDEADBEEF_CAFEF00D);

    op_chk("rd2c_misal", 1'b1, 1'b0, 64'h2C,  64'h0, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);
    op_chk("wr400_oor",  1'b0, 1'b1, 64'h400, 64'hFFFF, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);
    op_chk("rdhi_oor",   1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 3, 1'b1, 64'hDEADBEEF_CAFEF00D);
    op_chk("rd0",        1'b1, 1'b0, 64'h0,   64'h0, 3, 1'b0, 64'h1111);
    op_chk("rdwr8_conf", 1'b1, 1'b1, 64'h8,   64'hBAD, 3, 1'b1, 64'h1111);
    op_chk("rd8",        1'b1, 1'b0, 64'h8,   64'h0, 3, 1'b0, 64'h8888);
    op_chk("rd3f8_top",  1'b0, 1'b1, 64'h3F8, 64'h7777, 3, 1'b0, 64'h8888);
    op_chk("rd3f8",      1'b1, 1'b0, 64'h3F8, 64'h0, 3, 1'b0, 64'h7777);

    // reset while the write sits in WAIT
    drive(1'b0, 1'b1, 64'h10, 64'h1234);
    @(posedge CLK); @(negedge CLK);
    Reset_L = 1'b0;
    #1;
    check("rst_rdy", {63'd0, bus2.Ready}, 64'd0);
    check("rst_rd",  bus2.ReadData, 64'd0);
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_hold_rdy", {63'd0, bus2.Ready}, 64'd0);
    end
    Reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_rst_rdy", {63'd0, bus2.Ready}, 64'd0);
    end
    op_chk("rd10_after_rst", 1'b1, 1'b0, 64'h10, 64'h0, 3, 1'b0, 64'h5555);

    // zero-wait responder, request held across two writes
    tgt = 1'b1;
    drive(1'b0, 1'b1, 64'h0, 64'd1);
    n = 0; r1 = 0; r2 = 0;
    while (n < 12 && r2 == 0) begin
      @(posedge CLK); n++; @(negedge CLK);
      if (m_rdy) begin
        if (r1 == 0) begin
          r1 = n;
          drive(1'b0, 1'b1, 64'h8, 64'd2);
        end else begin
          r2 = n;
          drive(1'b0, 1'b0, '0, '0);
        end
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    @(posedge CLK); @(negedge CLK);
    check("b2b_first",  64'(r1), 64'd1);
    check("b2b_second", 64'(r2), 64'd3);
    op_chk("w0_rd0", 1'b1, 1'b0, 64'h0, 64'h0, 1, 1'b0, 64'd1);
    op_chk("w0_rd8", 1'b1, 1'b0, 64'h8, 64'h0, 1, 1'b0, 64'd2);
    op_chk("w0_misal", 1'b1, 1'b0, 64'h9, 64'h0, 1, 1'b1, 64'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
